// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared types and helpers for the VGA timing generator.
// Holds the axis phase enum, the per-axis timing struct and the decode helpers
// used by both axis counters.
package vga_timing_pkg;

  // Width of every field in the timing struct; CW of the generator must not exceed it.
  localparam int TIMING_W = 16;

  typedef enum logic [1:0] {
    DISP  = 2'd0,
    FRONT = 2'd1,
    SYNC  = 2'd2,
    BACK  = 2'd3
  } phase_t;

  typedef struct packed {
    logic [TIMING_W-1:0] disp;
    logic [TIMING_W-1:0] front;
    logic [TIMING_W-1:0] sync;
    logic [TIMING_W-1:0] back;
  } timing_t;

  // Total positions per axis period, widened so four maximal fields cannot overflow.
  function automatic logic [TIMING_W+1:0] total_of(input timing_t t);
    logic [TIMING_W+1:0] sum;
    sum = {2'b00, t.disp} + {2'b00, t.front} + {2'b00, t.sync} + {2'b00, t.back};
    return sum;
  endfunction

  // Phase of a position: DISP, then FRONT, then SYNC, remainder BACK.
  function automatic phase_t phase_of(input logic [TIMING_W-1:0] pos, input timing_t t);
    logic [TIMING_W+1:0] p;
    logic [TIMING_W+1:0] e_disp;
    logic [TIMING_W+1:0] e_front;
    logic [TIMING_W+1:0] e_sync;
    phase_t              ph;
    p       = {2'b00, pos};
    e_disp  = {2'b00, t.disp};
    e_front = e_disp + {2'b00, t.front};
    e_sync  = e_front + {2'b00, t.sync};
    if (p < e_disp)       ph = DISP;
    else if (p < e_front) ph = FRONT;
    else if (p < e_sync)  ph = SYNC;
    else                  ph = BACK;
    return ph;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_ctr.sv
// vga_axis_ctr: one axis of the timing generator. A single position counter
// walks DISP -> FRONT -> SYNC -> BACK and wraps to 0 after the last position;
// the phase is decoded from the position so it can only follow that order.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  timing_t       tim,
  output logic [CW-1:0] pos,
  output phase_t        phase,
  output logic          wrap
);

  logic [TIMING_W+1:0] last_pos;
  logic [TIMING_W+1:0] pos_ext;

  assign last_pos = total_of(tim) - (TIMING_W+2)'(1);
  assign pos_ext  = (TIMING_W+2)'(pos);
  assign wrap     = step && (pos_ext >= last_pos);
  assign phase    = phase_of(TIMING_W'(pos), tim);

  // Advance the position on each step, returning to 0 after the last position.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
    end else if (wrap) begin
      pos <= '0;
    end else if (step) begin
      pos <= pos + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal plus vertical VGA/SVGA timing generator.
// The h axis steps on every pixel enable; the v axis steps on the h wrap.
// All outputs are registered and show the position held on the previous ce.
// Optional macro VGA_TIMING_CFG_EN adds run-time timing registers that take
// effect only at a frame boundary.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP     = 1280,
  parameter int H_FRONT    = 48,
  parameter int H_SYNC     = 112,
  parameter int H_BACK     = 248,
  parameter int V_DISP     = 1024,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 38,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1,
  parameter int CW         = 12,
  parameter int FW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
`ifdef VGA_TIMING_CFG_EN
  input  logic [CW-1:0] cfg_h_disp,
  input  logic [CW-1:0] cfg_h_front,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_back,
  input  logic [CW-1:0] cfg_v_disp,
  input  logic [CW-1:0] cfg_v_front,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_back,
  input  logic          cfg_load,
`endif
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_disp,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic [FW-1:0] o_frame_cnt
);

  localparam longint H_TOTAL = longint'(H_DISP) + H_FRONT + H_SYNC + H_BACK;
  localparam longint V_TOTAL = longint'(V_DISP) + V_FRONT + V_SYNC + V_BACK;
  localparam logic   HS_ON   = (H_SYNC_POL != 0);
  localparam logic   VS_ON   = (V_SYNC_POL != 0);

  localparam timing_t H_PARAM = {TIMING_W'(H_DISP), TIMING_W'(H_FRONT),
                                 TIMING_W'(H_SYNC), TIMING_W'(H_BACK)};
  localparam timing_t V_PARAM = {TIMING_W'(V_DISP), TIMING_W'(V_FRONT),
                                 TIMING_W'(V_SYNC), TIMING_W'(V_BACK)};

  if (H_DISP == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_DISP == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_phase
    $error("vga_timing_gen: every phase length must be non-zero");
  end
  if (H_TOTAL > (64'd1 << CW) || V_TOTAL > (64'd1 << CW)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (CW > TIMING_W) begin : g_bad_cw
    $error("vga_timing_gen: CW exceeds the timing struct field width");
  end

  timing_t       h_tim;
  timing_t       v_tim;
  logic [CW-1:0] h_pos;
  logic [CW-1:0] v_pos;
  phase_t        h_phase;
  phase_t        v_phase;
  logic          h_wrap;
  logic          v_wrap;
  logic          v_step;
  logic [FW-1:0] frame_cnt;

`ifdef VGA_TIMING_CFG_EN
  timing_t h_pend;
  timing_t v_pend;
  timing_t h_act;
  timing_t v_act;
  logic    frame_wrap;

  assign frame_wrap = h_wrap && v_wrap;
  assign h_tim      = h_act;
  assign v_tim      = v_act;

  // Capture loads into the pending set and promote it only when a frame wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_pend <= H_PARAM;
      v_pend <= V_PARAM;
      h_act  <= H_PARAM;
      v_act  <= V_PARAM;
    end else begin
      if (cfg_load) begin
        h_pend <= {TIMING_W'(cfg_h_disp), TIMING_W'(cfg_h_front),
                   TIMING_W'(cfg_h_sync), TIMING_W'(cfg_h_back)};
        v_pend <= {TIMING_W'(cfg_v_disp), TIMING_W'(cfg_v_front),
                   TIMING_W'(cfg_v_sync), TIMING_W'(cfg_v_back)};
      end
      if (frame_wrap) begin
        h_act <= h_pend;
        v_act <= v_pend;
      end
    end
  end
`else
  assign h_tim = H_PARAM;
  assign v_tim = V_PARAM;
`endif

  assign v_step = h_wrap && ce;

  vga_axis_ctr #(.CW(CW)) u_h_ctr (
    .clk   (clk),
    .rst   (rst),
    .step  (ce),
    .tim   (h_tim),
    .pos   (h_pos),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_ctr #(.CW(CW)) u_v_ctr (
    .clk   (clk),
    .rst   (rst),
    .step  (v_step),
    .tim   (v_tim),
    .pos   (v_pos),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // Count completed frames; the registered copy below lines it up with the frame strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + FW'(1);
    end
  end

  // Register the decoded position on each pixel enable; everything holds while ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_hsync       <= ~HS_ON;
      o_vsync       <= ~VS_ON;
      o_disp        <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else if (ce) begin
      o_hsync       <= (h_phase == SYNC) ? HS_ON : ~HS_ON;
      o_vsync       <= (v_phase == SYNC) ? VS_ON : ~VS_ON;
      o_disp        <= (h_phase == DISP) && (v_phase == DISP);
      o_x           <= ((h_phase == DISP) && (v_phase == DISP)) ? h_pos : '0;
      o_y           <= ((h_phase == DISP) && (v_phase == DISP)) ? v_pos : '0;
      o_line_start  <= (h_pos == '0);
      o_frame_start <= (h_pos == '0) && (v_pos == '0);
      o_frame_cnt   <= frame_cnt;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised horizontal plus vertical VGA/SVGA timing generator; successor to the single-axis line timer.
- Two cascaded four-phase state machines (DISP, FRONT, SYNC, BACK), each driven by a single position counter per axis.
- Per-axis sync polarity, a pixel clock-enable, pixel coordinates, line/frame start strobes and a frame counter.
- Sits between the pixel clock domain and the pixel source / DAC output stage.

Parameters:
- H_DISP, 1280, active pixels per line
- H_FRONT, 48, horizontal front porch in pixels
- H_SYNC, 112, hsync width in pixels
- H_BACK, 248, horizontal back porch in pixels
- V_DISP, 1024, active lines per frame
- V_FRONT, 1, vertical front porch in lines
- V_SYNC, 3, vsync width in lines
- V_BACK, 38, vertical back porch in lines
- H_SYNC_POL, 1, hsync asserted level (1 = active-high)
- V_SYNC_POL, 1, vsync asserted level
- CW, 12, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FW, 8, frame counter width

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- ce  in  1  pixel enable; the generator advances one pixel per cycle with ce=1
- o_hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- o_vsync  out  1  vertical sync, polarity per V_SYNC_POL
- o_disp  out  1  display enable; high only when both axes are in DISP
- o_x  out  CW  pixel column, 0..H_DISP-1 while o_disp, else 0
- o_y  out  CW  pixel row, 0..V_DISP-1 while o_disp, else 0
- o_line_start  out  1  one-ce-cycle strobe at h_pos==0
- o_frame_start  out  1  one-ce-cycle strobe at h_pos==0 && v_pos==0
- o_frame_cnt  out  FW  completed-frame counter

Behaviour:
- Totals: H_TOTAL = H_DISP+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Internal counters h_pos, v_pos are CW bits wide.
- h phase from h_pos:
  - DISP: [0, H_DISP)
  - FRONT: [H_DISP, +H_FRONT)
  - SYNC: next H_SYNC positions
  - BACK: remainder
- v phase decodes identically from v_pos.
- Transitions are strictly DISP->FRONT->SYNC->BACK->DISP; no other transitions are legal.
- On ce=1:
  - h_pos increments; at H_TOTAL-1 it wraps to 0.
  - v_pos increments only on that same wrap; at V_TOTAL-1 with the h wrap, it wraps to 0.
  - o_frame_cnt increments on the v_pos wrap, modulo 2^FW.
- ce=0: counters and all outputs hold. Strobes stay high if they were high; they are "per ce-cycle", not per clk.
- All outputs are registered and reflect the position the counters held on the previous ce cycle (1 ce-cycle latency).
  - First ce after reset release: outputs show position (0,0) with o_disp=1, o_line_start=1, o_frame_start=1.
- o_hsync is at the asserted level iff h phase is SYNC. o_vsync is at the asserted level iff v phase is SYNC; it changes at h_pos==0 boundaries only.
- Reset (clk edge with rst=1):
  - h_pos=0, v_pos=0, o_frame_cnt=0.
  - o_disp=0, o_x=0, o_y=0, strobes 0.
  - o_hsync=!H_SYNC_POL, o_vsync=!V_SYNC_POL.
  - rst overrides ce.
  - A mid-frame reset abandons the frame with no partial sync pulse extension.
- Simultaneous h and v wrap: v_pos, o_frame_cnt and the strobes all update in the same ce cycle.
- Elaboration errors: any phase parameter = 0, or H_TOTAL or V_TOTAL > 2^CW.

Optional Feature:
- Macro VGA_TIMING_CFG_EN.
- Defined:
  - Adds inputs cfg_h_disp, cfg_h_front, cfg_h_sync, cfg_h_back, cfg_v_disp, cfg_v_front, cfg_v_sync, cfg_v_back (CW each) and cfg_load (1).
  - A cfg_load pulse captures all eight values into a pending shadow register set.
  - The pending set is applied to the active timing at the next frame wrap (v_pos and h_pos wrapping together), never mid-frame.
  - Multiple loads within one frame: last one wins.
  - The active set resets to the parameter values.
- Undefined:
  - Timing is fixed by the parameters; no cfg ports exist.

Decomposition:
- Package vga_timing_pkg:
  - phase enum (DISP=2'd0, FRONT=2'd1, SYNC=2'd2, BACK=2'd3).
  - A timing-struct typedef holding the four phase lengths.
  - A function returning the phase for a given pos and struct.
- Sub-module vga_axis_ctr, instantiated twice (h and v):
  - inputs: step enable and timing struct.
  - outputs: pos, phase, wrap.
  - The v instance's step is the h instance's wrap ANDed with ce.

Test Plan:
- Small parameters H=8/2/3/3 (H_TOTAL=16), V=4/1/2/1 (V_TOTAL=8), ce=1:
  - o_hsync asserted for exactly 3 clk per 16.
  - o_disp high for 8 clk per line on lines 0-3 only.
  - o_frame_start period = 128 clk.
- Same parameters, polarity and reset:
  - With H_SYNC_POL=0, check o_hsync idle high and low during h_pos 10-12.
  - During rst, all outputs are at their reset values.
  - First ce after release shows o_x=0, o_y=0, o_disp=1.
- ce toggled 1-0-1 with a random duty:
  - Output sequence matches the ce=1 run with the ce=0 cycles removed.
  - Strobes hold through ce=0.
- rst asserted at h_pos=11, v_pos=5 (mid-vsync):
  - o_vsync returns to its idle level on the next clk.
  - Restart begins at (0,0) and o_frame_cnt=0.
- Run 2^FW+1 frames with FW=2:
  - o_frame_cnt sequence 0,1,2,3,0,1.
  - Increments coincide with o_frame_start.
- VGA_TIMING_CFG_EN, cfg_load with cfg_h_disp=6 mid-frame:
  - The current frame keeps 8-pixel lines.
  - From the next o_frame_start, o_disp is 6 clk per line and H_TOTAL=14.
